// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Built-in self-test for a two-input gate bank. The block drives a/b
//   through the combinations 00, 01, 10, 11 and holds each one for SETTLE
//   cycles. It then compares the seven gate outputs against their truth
//   table. At the end of the sweep it reports a pass flag, a mismatch count,
//   a per-gate failure mask and a per-combination failure vector.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (only honoured while idle)
//   a, b       registered stimulus to the gate bank
//   xor_in .. nor_in   gate bank outputs under test
//   busy       high whenever a sweep is in progress (including the done cycle)
//   done       one-cycle pulse marking the end of a sweep
//   pass       last sweep had no mismatches; held until the next accepted start
//   err_cnt    total mismatching output bits in the last sweep
//   fail_mask  per gate: [0] xor [1] xnor [2] and [3] nand [4] not [5] or [6] nor
//   fail_vec   bit k set when combination k = {a,b} had any mismatch
module gate_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             xor_in,
  input  logic             xnor_in,
  input  logic             and_in,
  input  logic             nand_in,
  input  logic             not_in,
  input  logic             or_in,
  input  logic             nor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [6:0]       fail_mask,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       combo;
  logic [1:0]       combo_inc;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       obs;
  logic [6:0]       expect_bits;
  logic [6:0]       mis;
  logic [ERR_W-1:0] err_nxt;

  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Expected outputs, in fail_mask bit order, for the stimulus currently on a/b.
  always_comb begin
    expect_bits = {~(a | b), a | b, ~a, ~(a & b), a & b, ~(a ^ b), a ^ b};
    obs         = {nor_in, or_in, not_in, nand_in, and_in, xnor_in, xor_in};
    // An X or Z on any input propagates through the XOR. It therefore
    // never compares as a clean match.
    mis         = obs ^ expect_bits;
    err_nxt     = err_cnt + ERR_W'(popcount7(mis));
    combo_inc   = combo + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WAIT;
      S_WAIT:   if (cnt == '0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (combo == 2'd3) ? S_DONE : S_WAIT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= 1'b0;
      b         <= 1'b0;
      combo     <= 2'd0;
      cnt       <= '0;
      err_cnt   <= '0;
      fail_mask <= 7'd0;
      fail_vec  <= 4'd0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (start) begin
            err_cnt   <= '0;
            fail_mask <= 7'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
            combo     <= 2'd0;
            cnt       <= CNT_RELOAD;
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_SAMPLE: begin
          err_cnt         <= err_nxt;
          fail_mask       <= fail_mask | mis;
          fail_vec[combo] <= |mis;
          if (combo == 2'd3) begin
            a    <= 1'b0;
            b    <= 1'b0;
            // pass is computed from the final count here. This makes it valid
            // in the same cycle that done is high.
            pass <= (err_nxt == '0);
          end else begin
            combo <= combo_inc;
            a     <= combo_inc[1];
            b     <= combo_inc[0];
            cnt   <= CNT_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
